// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// Quotient goes to LO, remainder to HI. One shift-subtract iteration per clock.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 divide request, held high by EX until done
//   signed_div            1 = DIV (signed), 0 = DIVU
//   annul                 flush; aborts any operation in progress (beats start)
//   dividend, divisor     operands, sampled only on the accepting edge
//   stall_request         start & ~done, to pipeline control
//   busy                  FSM not idle
//   done                  one-cycle pulse, results valid in the same cycle
//   quotient, remainder   registered results, held until the next completion
//   div_by_zero           registered flag, valid with done
//
// Optional feature (macro DIV_EARLY_OUT_EN): when |dividend| < |divisor| the
// result (quotient 0, remainder = dividend) is produced without iterating.
module iterative_divider #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic                  annul,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  stall_request,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int unsigned W = DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StDivZero, StOn, StEnd} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   dq_q;       // dividend magnitude shifting out, quotient bits shifting in
  logic [W-1:0]   dvs_q;      // divisor magnitude
  logic [W-1:0]   prem_q;     // partial remainder (always < divisor, so W bits suffice)
  logic [CNT_WIDTH-1:0] cnt_q;
  logic           neg_q_q, neg_r_q;

  // Operand magnitudes for the accepting edge
  logic           dividend_neg, divisor_neg, divisor_zero;
  logic [W-1:0]   dividend_mag, divisor_mag;

  assign dividend_neg = signed_div & dividend[W-1];
  assign divisor_neg  = signed_div & divisor[W-1];
  assign dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
  assign divisor_mag  = divisor_neg  ? (~divisor + 1'b1)  : divisor;
  assign divisor_zero = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  logic early_out;
  assign early_out = (dividend_mag < divisor_mag);
`endif

  // One restoring iteration on a (W+1)-bit partial remainder
  logic [W:0]     shifted, trial;
  logic           q_bit;
  logic [W-1:0]   prem_next, dq_next, q_fix, r_fix;
  logic           last_iter;

  assign shifted   = {prem_q, dq_q[W-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign q_bit     = ~trial[W];
  assign prem_next = q_bit ? trial[W-1:0] : shifted[W-1:0];
  assign dq_next   = {dq_q[W-2:0], q_bit};
  // MIN / -1 wraps naturally: magnitude 2^(W-1) negated is itself
  assign q_fix     = neg_q_q ? (~dq_next + 1'b1)   : dq_next;
  assign r_fix     = neg_r_q ? (~prem_next + 1'b1) : prem_next;
  assign last_iter = (cnt_q == CNT_WIDTH'(W - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (annul) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (divisor_zero) begin
              state_d = StDivZero;
`ifdef DIV_EARLY_OUT_EN
            end else if (early_out) begin
              state_d = StEnd;
`endif
            end else begin
              state_d = StOn;
            end
          end
        end
        StOn:      if (last_iter) state_d = StEnd;
        StDivZero: state_d = StEnd;
        StEnd:     state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Outputs derived from state
  always_comb begin
    busy          = (state_q != StIdle);
    done          = (state_q == StEnd);
    stall_request = start & ~done;
  end

  // Datapath and result registers; annul freezes everything except the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_q        <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (!annul) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // Divide-by-zero keeps the raw dividend for the remainder result
            dq_q    <= divisor_zero ? dividend : dividend_mag;
            dvs_q   <= divisor_mag;
            prem_q  <= '0;
            cnt_q   <= '0;
            neg_q_q <= dividend_neg ^ divisor_neg;
            neg_r_q <= dividend_neg;
`ifdef DIV_EARLY_OUT_EN
            if (!divisor_zero && early_out) begin
              quotient    <= '0;
              remainder   <= dividend;
              div_by_zero <= 1'b0;
            end
`endif
          end
        end
        StOn: begin
          dq_q   <= dq_next;
          prem_q <= prem_next;
          cnt_q  <= cnt_q + CNT_WIDTH'(1);
          if (last_iter) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end
        end
        StDivZero: begin
          quotient    <= '1;
          remainder   <= dq_q;
          div_by_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall_request;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iterative_divider #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_div   (signed_div),
    .annul        (annul),
    .dividend     (dividend),
    .divisor      (divisor),
    .stall_request(stall_request),
    .busy         (busy),
    .done         (done),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero)
  );

`ifdef DIV_EARLY_OUT_EN
  localparam int EarlyCyc = 1;
`else
  localparam int EarlyCyc = 33;
`endif

  // Stimulus driver only: cycle 0 begins just after a rising edge; outputs are
  // sampled at the falling edge of each cycle. Drops start once done is seen.
  task automatic do_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble, output int done_cyc, output int done_cnt,
                       output logic [63:0] stall_hist, output logic post_done);
    done_cyc   = -1;
    done_cnt   = 0;
    stall_hist = '0;
    @(posedge clk); #1;
    signed_div = sd;
    dividend   = a;
    divisor    = b;
    start      = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      stall_hist[c] = stall_request;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk); #1;
      if (scramble && c == 2) begin
        dividend = 32'h1234_5678;
        divisor  = 32'h0000_0003;
      end
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
    @(negedge clk);
    post_done = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    dividend = '0; divisor = '0;
    #12;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    n_checks++;
    if (stall_request !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b want 0", stall_request);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_divu_basic();
    int dc, dn; logic [63:0] sh; logic pd;
    do_op(1'b0, 32'd100, 32'd7, 1'b0, dc, dn, sh, pd);
    n_checks++;
    if (dc !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d want 33", dc); end
    n_checks++;
    if (dn !== 1 || pd !== 1'b0) begin
      n_fail++; $display("FAIL divu_done_pulse: got count=%0d after=%b want 1/0", dn, pd);
    end
    n_checks++;
    if (sh[33:0] !== {1'b0, {33{1'b1}}}) begin
      n_fail++; $display("FAIL divu_stall: got %h want %h", sh[33:0], {1'b0, {33{1'b1}}});
    end
    n_checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL divu_100_7: got q=%0d r=%0d dbz=%b want 14 2 0",
                         quotient, remainder, div_by_zero);
    end
    do_op(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0, dc, dn, sh, pd);
    n_checks++;
    if (quotient !== 32'h0FFF_FFFF || remainder !== 32'hF) begin
      n_fail++; $display("FAIL divu_max_16: got q=%h r=%h want 0fffffff f", quotient, remainder);
    end
  endtask

  task automatic test_signed();
    int dc, dn; logic [63:0] sh; logic pd;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, dc, dn, sh, pd);
    n_checks++;
    if (dc !== 33 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL div_m7_2: got cyc=%0d q=%h r=%h want 33 fffffffd ffffffff",
                         dc, quotient, remainder);
    end
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, dc, dn, sh, pd);
    n_checks++;
    if (quotient !== 32'hFFFF_FFFD || remainder !== 32'd1) begin
      n_fail++; $display("FAIL div_7_m2: got q=%h r=%h want fffffffd 1", quotient, remainder);
    end
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, dc, dn, sh, pd);
    n_checks++;
    if (quotient !== 32'h8000_0000 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL div_overflow: got q=%h r=%h dbz=%b want 80000000 0 0",
                         quotient, remainder, div_by_zero);
    end
    // Same bits as DIVU: 0x80000000 / 0xFFFFFFFF = 0 rem 0x80000000
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, dc, dn, sh, pd);
    n_checks++;
    if (quotient !== 32'd0 || remainder !== 32'h8000_0000) begin
      n_fail++; $display("FAIL divu_big: got q=%h r=%h want 0 80000000", quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    int dc, dn; logic [63:0] sh; logic pd;
    do_op(1'b0, 32'd5, 32'd0, 1'b0, dc, dn, sh, pd);
    n_checks++;
    if (dc !== 2 || dn !== 1) begin
      n_fail++; $display("FAIL dbz_latency: got cyc=%0d count=%0d want 2 1", dc, dn);
    end
    n_checks++;
    if (div_by_zero !== 1'b1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd5) begin
      n_fail++; $display("FAIL dbz_result: got dbz=%b q=%h r=%h want 1 ffffffff 5",
                         div_by_zero, quotient, remainder);
    end
    do_op(1'b0, 32'd9, 32'd3, 1'b0, dc, dn, sh, pd);
    n_checks++;
    if (div_by_zero !== 1'b0 || quotient !== 32'd3 || remainder !== 32'd0) begin
      n_fail++; $display("FAIL dbz_clear: got dbz=%b q=%0d r=%0d want 0 3 0",
                         div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_annul();
    int dc, dn, seen; logic [63:0] sh; logic pd;
    // Previous op left q=3 r=0
    seen = 0;
    @(posedge clk); #1;
    signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    annul = 1'b1;  // cycle 10
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL annul_busy: got %b want 0", busy); end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); if (done === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL annul_no_done: got %0d pulses want 0", seen); end
    n_checks++;
    if (quotient !== 32'd3 || remainder !== 32'd0) begin
      n_fail++; $display("FAIL annul_hold: got q=%0d r=%0d want 3 0", quotient, remainder);
    end
    do_op(1'b0, 32'd9, 32'd2, 1'b0, dc, dn, sh, pd);
    n_checks++;
    if (dc !== 33 || quotient !== 32'd4 || remainder !== 32'd1) begin
      n_fail++; $display("FAIL annul_next: got cyc=%0d q=%0d r=%0d want 33 4 1",
                         dc, quotient, remainder);
    end
  endtask

  task automatic test_operand_hold();
    int dc, dn; logic [63:0] sh; logic pd;
    do_op(1'b0, 32'd1000, 32'd33, 1'b1, dc, dn, sh, pd);
    n_checks++;
    if (dc !== 33 || quotient !== 32'd30 || remainder !== 32'd10) begin
      n_fail++; $display("FAIL operand_hold: got cyc=%0d q=%0d r=%0d want 33 30 10",
                         dc, quotient, remainder);
    end
  endtask

  task automatic test_early_out();
    int dc, dn; logic [63:0] sh; logic pd;
    do_op(1'b1, 32'd3, 32'hFFFF_FFF6, 1'b0, dc, dn, sh, pd);
    n_checks++;
    if (dc !== EarlyCyc || quotient !== 32'd0 || remainder !== 32'd3) begin
      n_fail++; $display("FAIL early_3_m10: got cyc=%0d q=%h r=%h want %0d 0 3",
                         dc, quotient, remainder, EarlyCyc);
    end
    do_op(1'b1, 32'hFFFF_FFFD, 32'd10, 1'b0, dc, dn, sh, pd);
    n_checks++;
    if (dc !== EarlyCyc || quotient !== 32'd0 || remainder !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL early_m3_10: got cyc=%0d q=%h r=%h want %0d 0 fffffffd",
                         dc, quotient, remainder, EarlyCyc);
    end
  endtask

  task automatic test_reset_mid_op();
    int dc, dn; logic [63:0] sh; logic pd;
    do_op(1'b0, 32'd5, 32'd0, 1'b0, dc, dn, sh, pd);  // leaves dbz=1, q=all ones
    @(posedge clk); #1;
    signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;  // cycle 5
    #1;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_fail++; $display("FAIL reset_mid_op: got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
                         busy, done, div_by_zero, quotient, remainder);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 32'd100, 32'd7, 1'b0, dc, dn, sh, pd);
    n_checks++;
    if (dc !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
      n_fail++; $display("FAIL after_reset_op: got cyc=%0d q=%0d r=%0d want 33 14 2",
                         dc, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_annul();
    test_operand_hold();
    test_early_out();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Multi-cycle radix-2 restoring divider for the EX stage. Executes DIV/DIVU and writes quotient to LO and remainder to HI.
- Stalls the pipeline through its stall request while an operation is in flight. EX holds the instruction and operands stable until done.
- Generalises the single-cycle EX arithmetic with a parametrised data width, a state machine, an annul path and divide-by-zero handling.

Parameters:
- DATA_WIDTH, 32, operand and result width in bits (>=4).
- CNT_WIDTH, 6, iteration counter width; must hold the value DATA_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request divide; held high by EX until done.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU.
- annul  in  1  flush; abort any operation in progress.
- dividend  in  DATA_WIDTH  operand_1; stable while start is high.
- divisor  in  DATA_WIDTH  operand_2; stable while start is high.
- stall_request  out  1  to pipeline control; combinational: start & ~done.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse; results valid in the same cycle.
- quotient  out  DATA_WIDTH  to LO write data.
- remainder  out  DATA_WIDTH  to HI write data.
- div_by_zero  out  1  valid with done; divisor was zero.

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0. done, div_by_zero, quotient, remainder = 0. busy=0.
- States: IDLE, DIV_ZERO, ON, END.
- IDLE: start=1 & annul=0 at an edge, called e0 (cycle 0):
  - divisor==0 -> DIV_ZERO.
  - otherwise -> ON. Latch magnitudes: |x| for signed_div=1, raw value otherwise. Latch neg_q = sign(dividend)^sign(divisor) and neg_r = sign(dividend), both forced to 0 for DIVU. Clear partial remainder and counter.
- ON: one shift-subtract iteration per edge.
  - Partial remainder is (DATA_WIDTH+1) bits.
  - Quotient bit = 1 when the trial subtraction is non-negative.
  - Counter increments each iteration; after iteration DATA_WIDTH -> END.
- DIV_ZERO: -> END next edge with quotient=all ones, remainder=dividend (raw), div_by_zero=1.
- END: done=1 for exactly this cycle. quotient/remainder are the sign-corrected two's-complement values (negate if neg_q / neg_r). Next edge -> IDLE.
- Latency:
  - Normal: done in cycle DATA_WIDTH+1 (cycle 33 for 32 bits).
  - Divide by zero: done in cycle 2.
- quotient/remainder/div_by_zero stay registered and hold until the next END. div_by_zero clears on the next non-zero operation's END.
- Signed overflow (MIN / -1): quotient = MIN (wraps), remainder = 0. No exception.
- annul=1 in any state: -> IDLE at next edge. No done pulse; outputs keep their prior values. annul has priority over start.
- start still high in the cycle after done: treated as a new request (EX is required to drop start).
- Operand changes while busy are ignored; only values latched at e0 are used.
- rst mid-operation: immediate return to reset values.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if divisor!=0 and |dividend| < |divisor| (magnitudes), -> END at e0 with quotient=0 and remainder=dividend (raw, sign already correct); done in cycle 1.
- Undefined: such operations take the full DATA_WIDTH+1 latency with identical results.

Test Plan:
- DIVU 100/7, DATA_WIDTH=32 -> done in cycle 33 only; quotient=14, remainder=2; stall_request=1 in cycles 0..32, 0 in cycle 33.
- DIV -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- DIVU 5/0 -> done in cycle 2, div_by_zero=1, quotient=0xFFFFFFFF, remainder=5; next 9/3 -> div_by_zero=0, quotient=3.
- Start 100/7, assert annul in cycle 10 -> busy=0 from cycle 11, no done pulse, outputs unchanged; a new 9/2 then gives quotient=4, remainder=1 at cycle 33 of that op.
- Assert rst in cycle 5 of an operation -> all outputs 0 immediately, state IDLE.
- DIV_EARLY_OUT_EN defined: DIV 3/-10 -> done in cycle 1, quotient=0, remainder=3; undefined -> same values in cycle 33.
